serial_adder_ctrl: RTL and testbench

Bit-serial N-bit adder controller that time-shares a single full_adder_behav instance (ports a, b, cin, sum, cout) across all operand bits.
- Latches two WIDTH-bit operands and a carry-in on a start handshake.
- Feeds the full adder LSB-first for WIDTH cycles, holding the ripple carry in a flop between cycles.
- Presents the registered sum and carry-out with a one-cycle done pulse.
- Serves as the area-minimal multi-bit adder datapath built on the team's existing one-bit adder.

---
 rtl/serial_adder_ctrl.sv | 148 ++++++++++++++
 tb/tb_serial_adder_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// serial_adder_ctrl
//   Bit-serial WIDTH-bit adder. Operands and carry-in are captured on an
//   accepted start, then fed LSB-first through one shared one-bit full adder
//   over WIDTH cycles while the ripple carry is held in a flop. The result
//   is presented with a one-cycle done pulse.
//
//   Also defines full_adder_behav, the combinational one-bit adder reused
//   here.
//
//   Optional feature (macro SERIAL_ADDER_OVF_EN): adds ovf_out, the signed
//   overflow flag, registered with sum_out.
//
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   synchronous reset, active-low
//   start     in   add request, sampled only in IDLE
//   a_in      in   [WIDTH-1:0] operand A
//   b_in      in   [WIDTH-1:0] operand B
//   cin_in    in   carry-in
//   busy      out  high while the serial add runs
//   done      out  one-cycle pulse when sum_out/cout_out update
//   sum_out   out  [WIDTH-1:0] registered A+B+cin mod 2^WIDTH
//   cout_out  out  registered final carry-out
//   ovf_out   out  registered signed overflow (SERIAL_ADDER_OVF_EN only)
// ---------------------------------------------------------------------------

// One-bit combinational full adder.
module full_adder_behav (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum_out,
`ifdef SERIAL_ADDER_OVF_EN
    output logic             ovf_out,
`endif
    output logic             cout_out
);
    localparam int unsigned CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;

    logic             w_sum;
    logic             w_cout;
    logic [WIDTH-1:0] w_res_next;

    full_adder_behav u_fa (
        .a    (r_a[0]),
        .b    (r_b[0]),
        .cin  (r_carry),
        .sum  (w_sum),
        .cout (w_cout)
    );

    // Result fills from the MSB side so that after WIDTH shifts bit 0 is the LSB.
    assign w_res_next = {w_sum, r_res[WIDTH-1:1]};

    // Control FSM and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_res    <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            sum_out  <= '0;
            cout_out <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_out  <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                    if (start) begin
                        r_a     <= a_in;
                        r_b     <= b_in;
                        r_carry <= cin_in;
                        r_cnt   <= '0;
                        busy    <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    r_res   <= w_res_next;
                    r_carry <= w_cout;
                    r_cnt   <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(WIDTH - 1)) begin
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        sum_out  <= w_res_next;
                        cout_out <= w_cout;
`ifdef SERIAL_ADDER_OVF_EN
                        // r_carry is the carry into the MSB on this last bit.
                        ovf_out  <= r_carry ^ w_cout;
`endif
                        r_state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// tb_serial_adder_ctrl
//   Directed bench for serial_adder_ctrl (WIDTH=8). Expected results are
//   pushed to a scoreboard queue when an add is requested and popped when
//   done is observed. Define SERIAL_ADDER_OVF_EN to include ovf_out.
// ---------------------------------------------------------------------------
module tb_serial_adder_ctrl;
    localparam int unsigned W = 8;

    typedef struct packed {
        logic         ovf;
        logic         cout;
        logic [W-1:0] sum;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         cin_in;
    logic         busy;
    logic         done;
    logic [W-1:0] sum_out;
    logic         cout_out;
`ifdef SERIAL_ADDER_OVF_EN
    logic         ovf_out;
`endif

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a_in     (a_in),
        .b_in     (b_in),
        .cin_in   (cin_in),
        .busy     (busy),
        .done     (done),
        .sum_out  (sum_out),
`ifdef SERIAL_ADDER_OVF_EN
        .ovf_out  (ovf_out),
`endif
        .cout_out (cout_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: exact (W+1)-bit sum; signed overflow when same-sign operands
    // produce a result of the opposite sign.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic c);
        logic [W:0] full;
        exp_t       e;
        full   = {1'b0, a} + {1'b0, b} + (W+1)'(c);
        e.sum  = full[W-1:0];
        e.cout = full[W];
        e.ovf  = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
        return e;
    endfunction

    task automatic pop_and_compare(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_sum"}, 32'(sum_out), 32'(e.sum));
            chk({tag, "_cout"}, 32'(cout_out), 32'(e.cout));
`ifdef SERIAL_ADDER_OVF_EN
            chk({tag, "_ovf"}, 32'(ovf_out), 32'(e.ovf));
`endif
        end
    endtask

    // One add: start pulse, optional operand scrambling during RUN,
    // latency/busy-length checks and result comparison.
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic c, input bit scramble);
        int lat;
        int nbusy;
        bit got;
        @(negedge clk);
        start  = 1'b1;
        a_in   = a;
        b_in   = b;
        cin_in = c;
        exp_q.push_back(model(a, b, c));
        @(negedge clk);
        start = 1'b0;
        lat   = 1;
        nbusy = 0;
        got   = 1'b0;
        while (!got && lat < 30) begin
            if (done) begin
                got = 1'b1;
            end else begin
                if (busy) nbusy++;
                if (scramble) begin
                    a_in   = W'($urandom);
                    b_in   = W'($urandom);
                    cin_in = 1'($urandom);
                end
                @(negedge clk);
                lat++;
            end
        end
        chk({tag, "_done_seen"}, 32'(got), 32'd1);
        if (got) begin
            chk({tag, "_latency"}, 32'(lat), 32'(W + 1));
            chk({tag, "_busy_cycles"}, 32'(nbusy), 32'(W));
            chk({tag, "_busy_in_done"}, 32'(busy), 32'd0);
            pop_and_compare(tag);
            @(negedge clk);
            chk({tag, "_done_pulse_len"}, 32'(done), 32'd0);
        end else begin
            exp_q.delete();
        end
    endtask

    initial begin
        int   k;
        int   first_k;
        int   ndone;
        int   spurious;
        exp_t e0;

        // 1: reset dominates a held start.
        rst_n  = 1'b0;
        start  = 1'b1;
        a_in   = 8'hAA;
        b_in   = 8'h55;
        cin_in = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_done", 32'(done), 32'd0);
            chk("rst_sum", 32'(sum_out), 32'd0);
            chk("rst_cout", 32'(cout_out), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
            chk("rst_ovf", 32'(ovf_out), 32'd0);
`endif
        end
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_idle", 32'(busy), 32'd0);

        // 2, 3: basic adds and wrap-around.
        run_op("add_35_1a", 8'h35, 8'h1A, 1'b0, 1'b0);
        run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0);
        run_op("add_ff_ff_c", 8'hFF, 8'hFF, 1'b1, 1'b1);

        // 4: start held high, operands scrambled during RUN.
        @(negedge clk);
        start  = 1'b1;
        a_in   = 8'h10;
        b_in   = 8'h20;
        cin_in = 1'b0;
        exp_q.push_back(model(8'h10, 8'h20, 1'b0));
        k       = 0;
        first_k = 0;
        ndone   = 0;
        while (ndone < 2 && k < 40) begin
            @(negedge clk);
            k++;
            if (done) begin
                ndone++;
                pop_and_compare("held");
                if (ndone == 1) begin
                    first_k = k;
                    a_in    = 8'h44;
                    b_in    = 8'h22;
                    cin_in  = 1'b0;
                    exp_q.push_back(model(8'h44, 8'h22, 1'b0));
                end else begin
                    start = 1'b0;
                end
            end else if (busy) begin
                a_in   = W'($urandom);
                b_in   = W'($urandom);
                cin_in = 1'($urandom);
            end
        end
        start = 1'b0;
        chk("held_done_count", 32'(ndone), 32'd2);
        chk("held_first_latency", 32'(first_k), 32'(W + 1));
        chk("held_done_spacing", 32'(k - first_k), 32'(W + 2));
        exp_q.delete();

        // 5: reset during the 4th RUN cycle aborts the add.
        @(negedge clk);
        start  = 1'b1;
        a_in   = 8'h0F;
        b_in   = 8'h01;
        cin_in = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        chk("abort_busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_sum", 32'(sum_out), 32'd0);
        chk("abort_cout", 32'(cout_out), 32'd0);
        spurious = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done || busy) spurious++;
        end
        chk("abort_no_done", 32'(spurious), 32'd0);
        run_op("after_abort", 8'h0F, 8'h01, 1'b0, 1'b0);

        // 6: signed overflow corners (ovf checked when the feature is built).
        run_op("ovf_7f_01", 8'h7F, 8'h01, 1'b0, 1'b0);
        run_op("ovf_80_80", 8'h80, 8'h80, 1'b0, 1'b0);
        run_op("ovf_01_01", 8'h01, 8'h01, 1'b0, 1'b0);
        e0 = model(8'h7F, 8'h01, 1'b0);
        chk("model_7f_ovf", 32'(e0.ovf), 32'd1);

        // Random adds with scrambling.
        for (int i = 0; i < 6; i++) begin
            run_op("rand", W'($urandom), W'($urandom), 1'($urandom), 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
